// File: rtl/wt_mem_port_arbiter.sv
// Round-robin arbiter sharing the memory adapter port between I$ and D$,
// with per-requester outstanding throttling and source-tagged return routing.
module wt_mem_port_arbiter #(
    parameter int unsigned PayloadWidth   = 128,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    icache_data_req_i,
    output logic                    icache_data_ack_o,
    input  logic [PayloadWidth-1:0] icache_data_i,
    input  logic                    dcache_data_req_i,
    output logic                    dcache_data_ack_o,
    input  logic [PayloadWidth-1:0] dcache_data_i,
    output logic                    mem_data_req_o,
    input  logic                    mem_data_ack_i,
    output logic [PayloadWidth-1:0] mem_data_o,
    output logic                    mem_src_o,
    input  logic                    mem_rtrn_vld_i,
    input  logic                    mem_rtrn_src_i,
    output logic                    icache_rtrn_vld_o,
    output logic                    dcache_rtrn_vld_o,
    output logic                    idle_o,
    output logic                    err_o
);

    typedef enum logic {Idle, Busy} state_e;

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    state_e                state_q, state_d;
    logic                  gnt_src_q, gnt_src_d;
    logic                  rr_q, rr_d;
    logic [CntWidth-1:0]   cnt_i_q, cnt_i_d;
    logic [CntWidth-1:0]   cnt_d_q, cnt_d_d;
    logic                  err_q, err_d;

    logic busy, accept, elig_i, elig_d;
    logic inc_i, inc_d, rtrn_i, rtrn_d;
    logic zero_i, zero_d, dec_i, dec_d;

    assign busy   = (state_q == Busy);
    assign accept = busy && mem_data_ack_i;
    assign elig_i = icache_data_req_i && (cnt_i_q < CntMax);
    assign elig_d = dcache_data_req_i && (cnt_d_q < CntMax);
    assign inc_i  = accept && !gnt_src_q;
    assign inc_d  = accept && gnt_src_q;
    assign rtrn_i = mem_rtrn_vld_i && !mem_rtrn_src_i;
    assign rtrn_d = mem_rtrn_vld_i && mem_rtrn_src_i;
    assign zero_i = (cnt_i_q == '0);
    assign zero_d = (cnt_d_q == '0);
    // A return against an empty counter is flagged, never wrapped
    assign dec_i  = rtrn_i && !zero_i;
    assign dec_d  = rtrn_d && !zero_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            gnt_src_q <= 1'b0;
            rr_q      <= 1'b0;
            cnt_i_q   <= '0;
            cnt_d_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_src_q <= gnt_src_d;
            rr_q      <= rr_d;
            cnt_i_q   <= cnt_i_d;
            cnt_d_q   <= cnt_d_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_src_d = gnt_src_q;
        rr_d      = rr_q;
        unique case (state_q)
            Idle: begin
                if (elig_i || elig_d) begin
                    state_d   = Busy;
                    gnt_src_d = (elig_i && elig_d) ? rr_q : elig_d;
                end
            end
            Busy: begin
                if (mem_data_ack_i) begin
                    state_d = Idle;
                    rr_d    = ~gnt_src_q;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_comb begin
        cnt_i_d = cnt_i_q;
        cnt_d_d = cnt_d_q;
        unique case ({inc_i, dec_i})
            2'b10:   cnt_i_d = cnt_i_q + CntOne;
            2'b01:   cnt_i_d = cnt_i_q - CntOne;
            default: cnt_i_d = cnt_i_q;
        endcase
        unique case ({inc_d, dec_d})
            2'b10:   cnt_d_d = cnt_d_q + CntOne;
            2'b01:   cnt_d_d = cnt_d_q - CntOne;
            default: cnt_d_d = cnt_d_q;
        endcase
        err_d = err_q || (rtrn_i && zero_i) || (rtrn_d && zero_d);
    end

    always_comb begin
        mem_data_req_o    = busy;
        mem_src_o         = busy && gnt_src_q;
        mem_data_o        = '0;
        if (busy) begin
            mem_data_o = gnt_src_q ? dcache_data_i : icache_data_i;
        end
        icache_data_ack_o = inc_i;
        dcache_data_ack_o = inc_d;
        icache_rtrn_vld_o = rtrn_i;
        dcache_rtrn_vld_o = rtrn_d;
        idle_o            = !busy && zero_i && zero_d;
        err_o             = err_q;
    end

endmodule

// File: tb/tb_wt_mem_port_arbiter.sv
// Scoreboard bench for wt_mem_port_arbiter: requester models, auto ack/return,
// and a monitor that checks every grant and return against queued expectations.
module tb_wt_mem_port_arbiter;

    localparam int PW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ireq = 1'b0;
    logic          dreq = 1'b0;
    logic [PW-1:0] idata = '0;
    logic [PW-1:0] ddata = '0;
    logic          iack, dack, mreq, msrc, irv, drv, idle, err;
    logic [PW-1:0] mdata;

    logic ack_auto = 1'b0;
    logic ack_man = 1'b0;
    wire  mack = ack_auto ? mreq : ack_man;

    logic rtrn_auto = 1'b0;
    logic rv_a = 1'b0, rs_a = 1'b0, rv_m = 1'b0, rs_m = 1'b0;
    wire  rvld = rv_a | rv_m;
    wire  rsrc = rv_a ? rs_a : rs_m;

    int total = 0;
    int bad = 0;

    logic [PW-1:0] i_q[$], d_q[$], exp_i[$], exp_d[$];
    logic          exp_order[$];
    logic [1:0]    exp_rt[$];
    logic          i_acked = 1'b0, d_acked = 1'b0;
    logic          mon_s;
    logic [1:0]    mon_r;
    logic [PW-1:0] mon_p;
    logic          ar_p, ar_s;

    wt_mem_port_arbiter dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .icache_data_req_i (ireq),
        .icache_data_ack_o (iack),
        .icache_data_i     (idata),
        .dcache_data_req_i (dreq),
        .dcache_data_ack_o (dack),
        .dcache_data_i     (ddata),
        .mem_data_req_o    (mreq),
        .mem_data_ack_i    (mack),
        .mem_data_o        (mdata),
        .mem_src_o         (msrc),
        .mem_rtrn_vld_i    (rvld),
        .mem_rtrn_src_i    (rsrc),
        .icache_rtrn_vld_o (irv),
        .dcache_rtrn_vld_o (drv),
        .idle_o            (idle),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    task automatic fail(input string nm, input int act, input int exp);
        total++;
        bad++;
        $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [PW-1:0] act,
                        input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_i(input logic [PW-1:0] v);
        i_q.push_back(v);
        exp_i.push_back(v);
    endtask

    task automatic push_d(input logic [PW-1:0] v);
        d_q.push_back(v);
        exp_d.push_back(v);
    endtask

    task automatic do_rtrn(input logic s);
        @(posedge clk); #1;
        rv_m = 1'b1;
        rs_m = s;
        exp_rt.push_back({!s, s});
        @(posedge clk); #1;
        rv_m = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 400; k++) begin
            if (exp_order.size() == 0) break;
            @(negedge clk);
        end
        chkn(nm, exp_order.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req(input string nm);
        for (int k = 0; k < 50; k++) begin
            if (mreq) break;
            @(negedge clk);
        end
        chk1(nm, mreq, 1'b1);
    endtask

    // Scoreboard monitor: grants and returns
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mreq && mack) begin
                if (exp_order.size() == 0) begin
                    fail("unexpected_grant_src", int'(msrc), -1);
                end else begin
                    mon_s = exp_order.pop_front();
                    chk1("grant_src", msrc, mon_s);
                    if (!mon_s && exp_i.size() > 0) begin
                        mon_p = exp_i.pop_front();
                        chkw("grant_data_i", mdata, mon_p);
                    end else if (mon_s && exp_d.size() > 0) begin
                        mon_p = exp_d.pop_front();
                        chkw("grant_data_d", mdata, mon_p);
                    end else begin
                        fail("grant_no_payload", int'(mon_s), -1);
                    end
                    chk1("ack_i", iack, !mon_s);
                    chk1("ack_d", dack, mon_s);
                end
                if (iack) i_acked = 1'b1;
                if (dack) d_acked = 1'b1;
            end else if (iack || dack) begin
                fail("spurious_ack", int'({iack, dack}), 0);
            end
            if (rvld) begin
                if (exp_rt.size() == 0) begin
                    fail("unexpected_rtrn", int'({irv, drv}), -1);
                end else begin
                    mon_r = exp_rt.pop_front();
                    chkn("rtrn_route", int'({irv, drv}), int'(mon_r));
                end
            end else if (irv || drv) begin
                fail("spurious_rtrn", int'({irv, drv}), 0);
            end
        end
    end

    // I$ requester: holds request and payload until acked
    initial forever begin
        @(posedge clk); #1;
        if (i_acked) begin
            i_acked = 1'b0;
            if (i_q.size() > 0) i_q.delete(0);
        end
        if (i_q.size() > 0) begin
            ireq = 1'b1;
            idata = i_q[0];
        end else begin
            ireq = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (d_acked) begin
            d_acked = 1'b0;
            if (d_q.size() > 0) d_q.delete(0);
        end
        if (d_q.size() > 0) begin
            dreq = 1'b1;
            ddata = d_q[0];
        end else begin
            dreq = 1'b0;
        end
    end

    // Auto return: one cycle after each accepted grant
    initial forever begin
        @(negedge clk);
        ar_p = rtrn_auto && mreq && mack;
        ar_s = msrc;
        @(posedge clk); #1;
        rv_a = ar_p;
        rs_a = ar_s;
        if (ar_p) exp_rt.push_back({!ar_s, ar_s});
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk1("rst_mem_req", mreq, 1'b0);
        chk1("rst_ack_i", iack, 1'b0);
        chk1("rst_ack_d", dack, 1'b0);
        chk1("rst_src", msrc, 1'b0);
        chkw("rst_data", mdata, '0);
        chk1("rst_rtrn_i", irv, 1'b0);
        chk1("rst_rtrn_d", drv, 1'b0);
        chk1("rst_idle", idle, 1'b1);
        chk1("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // single I$ request, ack in second busy cycle
        @(negedge clk);
        push_i(128'h1111_0000_0000_00A1);
        exp_order.push_back(1'b0);
        @(negedge clk);
        chk1("t2_c0_req", mreq, 1'b0);
        @(negedge clk);
        chk1("t2_c1_req", mreq, 1'b1);
        chk1("t2_c1_src", msrc, 1'b0);
        chkw("t2_c1_data", mdata, 128'h1111_0000_0000_00A1);
        @(posedge clk); #1;
        ack_man = 1'b1;
        @(negedge clk);
        chk1("t2_c2_req", mreq, 1'b1);
        @(posedge clk); #1;
        ack_man = 1'b0;
        @(negedge clk);
        chk1("t2_after_req", mreq, 1'b0);
        chkn("t2_cnt_i", int'(dut.cnt_i_q), 1);
        chk1("t2_idle", idle, 1'b0);

        do_rtrn(1'b0);
        @(negedge clk);
        chk1("rtrn_idle", idle, 1'b1);
        chkn("rtrn_cnt_i", int'(dut.cnt_i_q), 0);
        chk1("rtrn_err", err, 1'b0);

        // return with nothing outstanding
        do_rtrn(1'b0);
        @(negedge clk);
        chk1("t6_err", err, 1'b1);
        chkn("t6_cnt_i", int'(dut.cnt_i_q), 0);

        // fairness: rr pointer now at D$
        rtrn_auto = 1'b1;
        ack_auto = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_d(128'hD000 + 128'(k));
            push_i(128'h1000 + 128'(k));
            exp_order.push_back(1'b1);
            exp_order.push_back(1'b0);
        end
        wait_drain("t3_drain");
        repeat (2) @(negedge clk);
        rtrn_auto = 1'b0;
        chk1("t3_idle", idle, 1'b1);
        chk1("t6_err_sticky", err, 1'b1);

        // throttle at MaxOutstanding
        for (int k = 0; k < 5; k++) push_i(128'h4400 + 128'(k));
        repeat (4) exp_order.push_back(1'b0);
        repeat (20) @(negedge clk);
        chkn("t4_four_granted", exp_order.size(), 0);
        chkn("t4_fifth_waits", i_q.size(), 1);
        chk1("t4_no_req", mreq, 1'b0);
        chkn("t4_cnt_i", int'(dut.cnt_i_q), 4);
        push_d(128'hD4D4);
        exp_order.push_back(1'b1);
        wait_drain("t4_d_granted");
        chkn("t4_cnt_d", int'(dut.cnt_d_q), 1);
        chkn("t4_fifth_still", i_q.size(), 1);
        exp_order.push_back(1'b0);
        do_rtrn(1'b0);
        wait_drain("t4_fifth_granted");
        chkn("t4_cnt_i_after", int'(dut.cnt_i_q), 4);
        repeat (4) do_rtrn(1'b0);
        do_rtrn(1'b1);
        @(negedge clk);
        chk1("t4_idle", idle, 1'b1);

        // ack and return on the same D$ counter
        for (int k = 0; k < 3; k++) begin
            push_d(128'h5500 + 128'(k));
            exp_order.push_back(1'b1);
        end
        wait_drain("t5_fill");
        ack_auto = 1'b0;
        push_d(128'h55FF);
        exp_order.push_back(1'b1);
        wait_req("t5_busy");
        @(posedge clk); #1;
        ack_man = 1'b1;
        rv_m = 1'b1;
        rs_m = 1'b1;
        exp_rt.push_back(2'b01);
        @(negedge clk);
        chk1("t5_rtrn_d", drv, 1'b1);
        @(posedge clk); #1;
        ack_man = 1'b0;
        rv_m = 1'b0;
        @(negedge clk);
        chkn("t5_cnt_d", int'(dut.cnt_d_q), 3);
        chkn("t5_granted", exp_order.size(), 0);
        repeat (3) do_rtrn(1'b1);
        @(negedge clk);
        chk1("t5_idle", idle, 1'b1);

        // reset mid-busy with two I$ outstanding
        ack_auto = 1'b1;
        push_i(128'h7700);
        push_i(128'h7701);
        exp_order.push_back(1'b0);
        exp_order.push_back(1'b0);
        wait_drain("t1_fill");
        ack_auto = 1'b0;
        push_i(128'h7702);
        wait_req("t1_busy");
        chkn("t1_cnt_pre", int'(dut.cnt_i_q), 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        i_q.delete();
        exp_i.delete();
        i_acked = 1'b0;
        #1;
        chk1("t1_req", mreq, 1'b0);
        chk1("t1_ack_i", iack, 1'b0);
        chk1("t1_src", msrc, 1'b0);
        chkw("t1_data", mdata, '0);
        chkn("t1_cnt_i", int'(dut.cnt_i_q), 0);
        chkn("t1_cnt_d", int'(dut.cnt_d_q), 0);
        chk1("t1_idle", idle, 1'b1);
        chk1("t1_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("t1_post_idle", idle, 1'b1);
        chk1("t1_post_req", mreq, 1'b0);
        chk1("t1_post_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
